// File: rtl/rx_uart.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid/error strobes.
// Define RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module rx_uart #(
    parameter int unsigned BPS_MAX = 5208,
    parameter int unsigned BIT_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [BIT_MAX-1:0] rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output logic               parity_err,
    output logic               busy
);

    localparam int unsigned CW   = $clog2(BPS_MAX);
    localparam int unsigned BW   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
    localparam int unsigned HALF = BPS_MAX / 2 - 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      bps_cnt_q, bps_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BIT_MAX-1:0] shift_q, shift_d;
    logic [BIT_MAX-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               rx_m, rx_s, rx_d;
    logic               start_edge, sample, boundary;
`ifdef RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign start_edge = rx_d & ~rx_s;
    assign sample     = (bps_cnt_q == CW'(HALF));
    assign boundary   = (bps_cnt_q == CW'(BPS_MAX - 1));

    always_comb begin
        state_d     = state_q;
        bps_cnt_d   = bps_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (state_q != StIdle) begin
            bps_cnt_d = boundary ? '0 : bps_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                bps_cnt_d = '0;
                if (start_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (sample && rx_s) begin
                    state_d   = StIdle;
                    bps_cnt_d = '0;
                end else if (boundary) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (sample) begin
                    shift_d[bit_cnt_q] = rx_s;
                end
                if (boundary) begin
                    if (bit_cnt_q == BW'(BIT_MAX - 1)) begin
                        bit_cnt_d = '0;
`ifdef RX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef RX_PARITY_EN
            StParity: begin
                if (sample) begin
                    par_bad_d = rx_s ^ (^shift_q);
                end
                if (boundary) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Return to idle at the sample point to leave margin for a back-to-back start bit.
                if (sample) begin
                    state_d   = StIdle;
                    bps_cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
`ifdef RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                bps_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bps_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bps_cnt_q   <= bps_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rx_uart.sv
// Randomised bench for rx_uart: serial frames are driven bit by bit, expected strobes go to a
// scoreboard queue, and a monitor pops and compares whenever the receiver strobes.
module tb_rx_uart;

    localparam int unsigned BPS  = 16;
    localparam int unsigned NB   = 8;
    localparam int unsigned HALF = BPS / 2 - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [NB-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0]    kind;  // 0 valid, 1 frame error, 2 parity error
        logic [NB-1:0] data;  // rx_data required at the strobe
    } ev_t;

    ev_t           exp_q[$];
    logic [NB-1:0] last_good = '0;

    rx_uart #(.BPS_MAX(BPS), .BIT_MAX(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (rx_valid || frame_err || parity_err)) begin
            logic [1:0] kind;
            ev_t        e;
            check("strobe_onehot", 32'(rx_valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
            check("busy_at_strobe", 32'(busy), 32'd0);
            kind = rx_valid ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_kind", 32'(kind), 32'd3);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(kind), 32'(e.kind));
                check("strobe_data", 32'(rx_data), 32'(e.data));
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (BPS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [NB-1:0] d, input logic stop_bit, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < int'(NB); i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_bit);
    endtask

    // Reference model: decides the frame outcome from the frame rules alone.
    task automatic expect_frame(input logic [NB-1:0] d, input logic stop_bit,
                                input logic par_bit);
        ev_t e;
        logic par_ok;
        par_ok = 1'b1;
`ifdef RX_PARITY_EN
        par_ok = (par_bit == ^d);
`endif
        if (!stop_bit) begin
            e = '{kind: 2'd1, data: last_good};
        end else if (!par_ok) begin
            e = '{kind: 2'd2, data: last_good};
        end else begin
            e = '{kind: 2'd0, data: d};
            last_good = d;
        end
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [NB-1:0] d, input logic stop_bit, input logic par_bit);
        expect_frame(d, stop_bit, par_bit);
        send_frame(d, stop_bit, par_bit);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int bad;
        logic [NB-1:0] d;
        logic stop_b, par_b;

        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_perr", 32'(parity_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);

        frame(8'hA5, 1'b1, ^8'hA5);
        idle(20);

        frame(8'h3C, 1'b1, ^8'h3C);
        frame(8'hFF, 1'b1, ^8'hFF);
        idle(20);

        // 3-cycle low glitch: receiver must abandon at the start-bit sample.
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        busy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        tests++;
        if (busy_cnt < int'(HALF) || busy_cnt > int'(HALF) + 2) begin
            fails++;
            $display("FAIL glitch_busy_cycles: got %0d, expected about %0d", busy_cnt, HALF + 1);
        end

        // Bad stop bit, then the line stays low: one frame error and no retrigger.
        frame(8'h81, 1'b0, ^8'h81);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) bad++;
        end
        check("stuck_low_busy_cycles", 32'(bad), 32'd0);
        idle(20);

        // Reset in the middle of data bit 4 abandons the frame silently.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(i & 1));
        @(negedge clk);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        last_good = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data", 32'(rx_data), 32'd0);
        idle(10);
        frame(8'h5A, 1'b1, ^8'h5A);
        idle(10);

`ifdef RX_PARITY_EN
        frame(8'h07, 1'b1, 1'b0);
        idle(10);
`endif

        // Randomised frames with random gaps (including none) and occasional bad stop/parity.
        for (int n = 0; n < 24; n++) begin
            d      = NB'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            par_b  = ^d ^ ($urandom_range(0, 7) == 0);
            frame(d, stop_b, par_b);
            if (!stop_b || $urandom_range(0, 1) == 1) idle($urandom_range(2, 30));
        end
        idle(5);

        bad = 0;
        while (exp_q.size() != 0 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
